// File: rtl/score_event_sequencer_pkg.sv
// Shared definitions for the score event sequencer: FSM encoding and
// game constants that the score display also depends on.
package score_event_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DEC_HI = 2'd1,
      INC_HI = 2'd2,
      GAP    = 2'd3
   } seq_state_t;

   localparam int START_LIVES_DEFAULT = 3;
   localparam int MAX_DIGIT           = 9;

endpackage

// File: rtl/score_event_sequencer_strobe_pacer.sv
// Phase timer for the strobe sequencer: a start pulse begins a phase and
// done is high in its last cycle (len cycles after the start edge).
module score_event_sequencer_strobe_pacer (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] len,
   output logic       done
);

   logic [3:0] cnt_reg;

   // The start edge itself opens the first cycle of the phase, hence load 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg <= 4'd0;
      end else if (start) begin
         cnt_reg <= 4'd1;
      end else if (cnt_reg != 4'hF) begin
         cnt_reg <= cnt_reg + 4'd1;
      end
   end

   assign done = (cnt_reg == len);

endmodule

// File: rtl/score_event_sequencer.sv
// Converts game-logic requests into paced incscore/declives strobes for
// player_stats and keeps a lives shadow to flag game over locally.
module score_event_sequencer
   import score_event_sequencer_pkg::*;
#(
   parameter int START_LIVES = START_LIVES_DEFAULT,
   parameter int HIGH_CYCLES = 1,
   parameter int GAP_CYCLES  = 4,
   parameter int PEND_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              add_pts_valid,
   input  logic [3:0]        add_pts,
   input  logic              lose_life,
   output logic              incscore,
   output logic              declives,
   output logic [3:0]        lives_shadow,
   output logic [PEND_W-1:0] pending_pts,
   output logic              busy,
   output logic              game_over
);

   localparam int PW1 = PEND_W + 1;

   seq_state_t        state_reg, state_next;
   logic [PEND_W-1:0] pend_pts_reg, pend_pts_next;
   logic [1:0]        pend_life_reg, pend_life_next;
   logic [3:0]        lives_reg, lives_next;
   logic              inc_reg, dec_reg;

   logic              pacer_start, pacer_done;
   logic [3:0]        pacer_len;
   logic              consume_inc, consume_dec, accept_life;
   logic [PW1-1:0]    pts_sum;

   assign pacer_len = (state_reg == GAP) ? 4'(GAP_CYCLES) : 4'(HIGH_CYCLES);

   score_event_sequencer_strobe_pacer u_pacer (
      .clk   (clk),
      .reset (reset),
      .start (pacer_start),
      .len   (pacer_len),
      .done  (pacer_done)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (pend_life_reg != 2'd0) begin
               state_next = DEC_HI;
            end else if (pend_pts_reg != '0) begin
               state_next = INC_HI;
            end
         end
         DEC_HI, INC_HI: begin
            if (pacer_done) begin
               state_next = GAP;
            end
         end
         GAP: begin
            if (pacer_done) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign pacer_start = (state_next != state_reg) && (state_next != IDLE);
   assign consume_inc = (state_reg == IDLE) && (state_next == INC_HI);
   assign consume_dec = (state_reg == IDLE) && (state_next == DEC_HI);

   // Pending lives may never exceed the lives that remain to be taken.
   assign accept_life = lose_life && !game_over &&
                        ({2'b00, pend_life_reg} < lives_reg) &&
                        (pend_life_reg != 2'd3);

   // Net update first, saturation last, so a strobe and a request in the
   // same cycle never lose a point.
   always_comb begin
      pts_sum = {1'b0, pend_pts_reg} - PW1'(consume_inc)
                + PW1'(add_pts_valid ? add_pts : 4'd0);
      pend_pts_next = pts_sum[PEND_W] ? {PEND_W{1'b1}} : pts_sum[PEND_W-1:0];
   end

   assign pend_life_next = pend_life_reg - 2'(consume_dec) + 2'(accept_life);
   assign lives_next     = lives_reg - 4'(consume_dec);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         pend_pts_reg  <= '0;
         pend_life_reg <= 2'd0;
         lives_reg     <= 4'(START_LIVES);
         inc_reg       <= 1'b0;
         dec_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pend_pts_reg  <= pend_pts_next;
         pend_life_reg <= pend_life_next;
         lives_reg     <= lives_next;
         inc_reg       <= (state_next == INC_HI);
         dec_reg       <= (state_next == DEC_HI);
      end
   end

   assign incscore     = inc_reg;
   assign declives     = dec_reg;
   assign lives_shadow = lives_reg;
   assign pending_pts  = pend_pts_reg;
   assign game_over    = (lives_reg == 4'd0);
   assign busy         = (state_reg != IDLE) || (pend_pts_reg != '0) ||
                         (pend_life_reg != 2'd0);

endmodule

// File: doc/score_event_sequencer.md
Name: score_event_sequencer

Overview:
- Producer side of the player-stats event interface: turns game-logic requests ("add N points", "lose a life") into paced single-event strobes on incscore/declives.
- Each incscore strobe advances the BCD score counter by one; each declives strobe removes one life.
- Sits between collision/game logic and player_stats. Keeps a lives shadow so it can flag game over without reading player_stats back.

Parameters:
- START_LIVES, 3, life count after reset; must equal the player_stats reset value.
- HIGH_CYCLES, 1, cycles each strobe is held high (1..15).
- GAP_CYCLES, 4, minimum low cycles after each strobe before the next one (1..15).
- PEND_W, 8, width of the pending-points accumulator.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- add_pts_valid  in  1  one-cycle request to add add_pts points
- add_pts  in  4  points to add (0..15)
- lose_life  in  1  one-cycle request to remove one life
- incscore  out  1  score strobe to player_stats
- declives  out  1  life strobe to player_stats
- lives_shadow  out  4  lives remaining after all issued declives strobes
- pending_pts  out  PEND_W  points accepted but not yet strobed
- busy  out  1  high when the FSM is not IDLE or any event is pending
- game_over  out  1  high while lives_shadow == 0

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values:
  - incscore = 0, declives = 0
  - lives_shadow = START_LIVES, pending_pts = 0, pending_life = 0
  - FSM = IDLE, busy = 0, game_over = (START_LIVES == 0)
- Request acceptance (every cycle, regardless of FSM state):
  - add_pts_valid with add_pts != 0: pending_pts += add_pts, saturating at 2^PEND_W-1. add_pts == 0 is ignored.
  - lose_life: accepted only if game_over = 0 and lives_shadow > pending_life. Sets pending_life (1-bit flag). A second lose_life while pending_life = 1 is counted only if lives_shadow > 1; otherwise it is dropped.
  - Pending lives are therefore tracked as a 2-bit counter pending_life_cnt, capped so it never exceeds lives_shadow.
  - A simultaneous add_pts_valid and lose_life are both accepted in the same cycle.
  - A request that arrives in the same cycle as a strobe consumes the counter uses the net update: pending_pts_next = pending_pts - consumed + added, with saturation applied last.
- FSM states: IDLE, DEC_HI, INC_HI, GAP.
  - IDLE: if pending_life_cnt > 0, go to DEC_HI; else if pending_pts > 0, go to INC_HI; else stay. Life events have priority over points.
  - On entry to DEC_HI: declives = 1, pending_life_cnt -= 1, lives_shadow -= 1 (at the entry edge).
  - On entry to INC_HI: incscore = 1, pending_pts -= 1 (at the entry edge).
  - DEC_HI and INC_HI hold for HIGH_CYCLES cycles via a 4-bit counter, then go to GAP with the strobe deasserted.
  - GAP: strobes low for GAP_CYCLES cycles, then IDLE.
  - Latency from request to strobe rising: 2 cycles when idle (request registered, then IDLE decides).
  - Period per event: 1 + HIGH_CYCLES + GAP_CYCLES cycles.
- incscore and declives are registered, glitch-free, and never high in the same cycle.
- lives_shadow never underflows. game_over is combinational from lives_shadow == 0 and rises in the cycle DEC_HI is entered with the last life.
- After game_over, points still pending are still strobed out; new lose_life requests are ignored.
- Reset mid-strobe: strobes go low on the reset edge and all pending events are discarded.
  - A strobe cut short still produced a rising edge, and player_stats has already counted it. The top level must therefore reset player_stats from the same reset.

Decomposition:
- Shared package/header:
  - FSM state encoding (2-bit: IDLE = 0, DEC_HI = 1, INC_HI = 2, GAP = 3)
  - START_LIVES default
  - Max-digit constant 9, shared with the score display
- One natural sub-module, strobe_pacer: the HIGH/GAP timer with a start input and a done output.
- Accumulator and arbitration stay in the top module.

Test Plan:
- Reset, then idle 20 cycles -> incscore = declives = 0, lives_shadow = 3, busy = 0, game_over = 0.
- add_pts = 5 once (HIGH = 1, GAP = 4) -> exactly 5 incscore pulses, 1 cycle wide, 6 cycles apart; first rising edge 2 cycles after the request; pending_pts counts down to 0.
- add_pts = 3 and lose_life in the same cycle -> one declives first, then 3 incscore pulses; lives_shadow = 2.
- Four lose_life requests spread out -> 3 declives pulses; lives_shadow = 0; game_over = 1; fourth request dropped, no pulse.
- add_pts = 15 every cycle for 40 cycles -> pending_pts saturates at 255 with no wrap; strobes continue at the paced rate.
- Reset asserted during the 2nd of 5 pending incscore pulses -> strobe low on the next edge, pending_pts = 0, no further pulses, lives_shadow = 3.
